// File: rtl/clock_set_controller.sv
// clock_set_controller: freezes the timekeeper, edits shadow h/m/s fields from buttons,
// then commits with a one-cycle load pulse or abandons the edit after an inactivity timeout.
module clock_set_controller #(
  parameter int HOUR_MAX    = 23,
  parameter int MIN_MAX     = 59,
  parameter int TIMEOUT_SEC = 10,
  parameter int TO_W        = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_mode_btn,
  input  logic       i_inc_btn,
  input  logic       i_dec_btn,
  input  logic       i_sec_tick,
  input  logic [4:0] i_cur_hours,
  input  logic [5:0] i_cur_minutes,
  input  logic [5:0] i_cur_seconds,
  output logic       o_run_en,
  output logic       o_load,
  output logic [4:0] o_set_hours,
  output logic [5:0] o_set_minutes,
  output logic [5:0] o_set_seconds,
  output logic [1:0] o_field,
  output logic       o_blink
);
  typedef enum logic [1:0] {RUN, EDIT_HR, EDIT_MIN, EDIT_SEC} state_t;
  state_t r_state, w_state_n;
  logic r_load, w_load_n, r_blink, w_blink_n;
  logic [4:0] r_hours, w_hours_n;
  logic [5:0] r_minutes, w_minutes_n, r_seconds, w_seconds_n;
  logic [TO_W-1:0] r_to_cnt, w_to_cnt_n, w_to_inc;
  logic w_btn, w_up, w_dn, w_capture, w_expire;

  // Values above mx (e.g. captured out-of-range time) wrap to 0 on inc and to mx on dec.
  function automatic logic [5:0] f_step(input logic [5:0] v, input logic [5:0] mx, input logic up, input logic dn);
    return up ? ((v >= mx) ? 6'd0 : v + 6'd1) : dn ? ((v == 6'd0 || v > mx) ? mx : v - 6'd1) : v;
  endfunction

  always_comb begin
    w_btn       = i_mode_btn | i_inc_btn | i_dec_btn;
    w_up        = i_inc_btn & ~i_dec_btn & ~i_mode_btn;
    w_dn        = i_dec_btn & ~i_inc_btn & ~i_mode_btn;
    w_capture   = (r_state == RUN) && i_mode_btn;
    w_to_inc    = r_to_cnt + 1'b1;
    w_expire    = (TIMEOUT_SEC != 0) && (r_state != RUN) && i_sec_tick && !w_btn && (w_to_inc == TO_W'(TIMEOUT_SEC));
    w_state_n   = i_mode_btn ? state_t'(r_state + 2'd1) : w_expire ? RUN : r_state;
    w_load_n    = (r_state == EDIT_SEC) && i_mode_btn;
    w_hours_n   = w_capture ? i_cur_hours : (r_state == EDIT_HR) ? 5'(f_step({1'b0, r_hours}, 6'(HOUR_MAX), w_up, w_dn)) : r_hours;
    w_minutes_n = w_capture ? i_cur_minutes : (r_state == EDIT_MIN) ? f_step(r_minutes, 6'(MIN_MAX), w_up, w_dn) : r_minutes;
    w_seconds_n = w_capture ? i_cur_seconds : (r_state == EDIT_SEC) ? f_step(r_seconds, 6'(MIN_MAX), w_up, w_dn) : r_seconds;
    w_to_cnt_n  = (w_btn || r_state == RUN || w_expire) ? '0 : i_sec_tick ? w_to_inc : r_to_cnt;
    w_blink_n   = (w_state_n == RUN) ? 1'b0 : (r_state == RUN) ? 1'b1 : r_blink ^ i_sec_tick;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= RUN;
      r_load    <= 1'b0;
      r_blink   <= 1'b0;
      r_hours   <= '0;
      r_minutes <= '0;
      r_seconds <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_state   <= w_state_n;
      r_load    <= w_load_n;
      r_blink   <= w_blink_n;
      r_hours   <= w_hours_n;
      r_minutes <= w_minutes_n;
      r_seconds <= w_seconds_n;
      r_to_cnt  <= w_to_cnt_n;
    end
  end

  assign o_run_en      = (r_state == RUN);
  assign o_load        = r_load;
  assign o_set_hours   = r_hours;
  assign o_set_minutes = r_minutes;
  assign o_set_seconds = r_seconds;
  assign o_field       = r_state;
  assign o_blink       = r_blink;
endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: vector table plus hand sequences; expected outputs queued at drive
// time and compared one cycle later when the registered outputs reflect the sampled inputs.
module tb_clock_set_controller;
  typedef struct packed {
    logic rst, m, i, d, t;
    logic [1:0] f;
    logic r, l;
    logic [4:0] h;
    logic [5:0] mi, s;
    logic b;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1, mode = 1'b0, inc = 1'b0, dec = 1'b0, tick = 1'b0;
  logic [4:0] cur_h = '0;
  logic [5:0] cur_m = '0, cur_s = '0;
  logic run_en, load, blink;
  logic [4:0] set_h;
  logic [5:0] set_m, set_s;
  logic [1:0] field;
  vec_t tbl[$];
  vec_t sb[$];
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  clock_set_controller #(.HOUR_MAX(23), .MIN_MAX(59), .TIMEOUT_SEC(10), .TO_W(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_mode_btn(mode), .i_inc_btn(inc), .i_dec_btn(dec),
    .i_sec_tick(tick), .i_cur_hours(cur_h), .i_cur_minutes(cur_m), .i_cur_seconds(cur_s),
    .o_run_en(run_en), .o_load(load), .o_set_hours(set_h), .o_set_minutes(set_m),
    .o_set_seconds(set_s), .o_field(field), .o_blink(blink)
  );

  function automatic vec_t mk(input logic r_, m_, i_, d_, t_, input logic [1:0] f_, input logic re_, le_,
                              input int h_, mi_, s_, input logic b_);
    vec_t v;
    v = '{rst: r_, m: m_, i: i_, d: d_, t: t_, f: f_, r: re_, l: le_, h: 5'(h_), mi: 6'(mi_), s: 6'(s_), b: b_};
    return v;
  endfunction

  task automatic chk();
    vec_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if ({field, run_en, load, set_h, set_m, set_s, blink} !== {e.f, e.r, e.l, e.h, e.mi, e.s, e.b}) begin
        n_err++;
        $display("FAIL vec %0d: got field=%0d run_en=%b load=%b set=%0d:%0d:%0d blink=%b, want field=%0d run_en=%b load=%b set=%0d:%0d:%0d blink=%b",
                 n_vec, field, run_en, load, set_h, set_m, set_s, blink, e.f, e.r, e.l, e.h, e.mi, e.s, e.b);
      end
    end
  endtask

  task automatic go(input vec_t v);
    @(negedge clk);
    chk();
    {rst, mode, inc, dec, tick} = {v.rst, v.m, v.i, v.d, v.t};
    sb.push_back(v);
  endtask

  task automatic tick_run(input int a, input int z, input logic [1:0] f, input int h, input int mi, input int s);
    for (int k = a; k <= z; k++) begin
      go(mk(0, 0, 0, 0, 1, f, 0, 0, h, mi, s, (k % 2) == 0));
      go(mk(0, 0, 0, 0, 0, f, 0, 0, h, mi, s, (k % 2) == 0));
    end
  endtask

  initial begin
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 12, 34, 56, 1));
    for (int k = 1; k <= 3; k++) tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 12 + k, 34, 56, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 2, 0, 0, 15, 34, 56, 1));
    for (int k = 1; k <= 35; k++) tbl.push_back(mk(0, 0, 0, 1, 0, 2, 0, 0, 15, (94 - k) % 60, 56, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 3, 0, 0, 15, 59, 56, 1));
    for (int k = 1; k <= 4; k++) tbl.push_back(mk(0, 0, 1, 0, 0, 3, 0, 0, 15, 59, (56 + k) % 60, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 15, 59, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 15, 59, 0, 0));

    {cur_h, cur_m, cur_s} = {5'd12, 6'd34, 6'd56};
    for (int k = 0; k < tbl.size(); k++) go(tbl[k]);

    // wrap rules, mode priority over inc, inc+dec cancel, out-of-range capture
    @(negedge clk);
    {cur_h, cur_m, cur_s} = {5'd23, 6'd62, 6'd0};
    go(mk(0, 1, 0, 0, 0, 1, 0, 0, 23, 62, 0, 1));
    go(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 62, 0, 1));
    go(mk(0, 0, 0, 1, 0, 1, 0, 0, 23, 62, 0, 1));
    go(mk(0, 1, 1, 0, 0, 2, 0, 0, 23, 62, 0, 1));
    go(mk(0, 0, 1, 0, 0, 2, 0, 0, 23, 0, 0, 1));
    go(mk(0, 0, 0, 1, 0, 2, 0, 0, 23, 59, 0, 1));
    go(mk(0, 0, 1, 1, 0, 2, 0, 0, 23, 59, 0, 1));
    go(mk(0, 0, 0, 0, 1, 2, 0, 0, 23, 59, 0, 0));
    go(mk(0, 1, 0, 0, 0, 3, 0, 0, 23, 59, 0, 0));
    go(mk(0, 1, 0, 0, 0, 0, 1, 1, 23, 59, 0, 0));
    go(mk(0, 0, 0, 0, 0, 0, 1, 0, 23, 59, 0, 0));

    // plain timeout: abort on 10th idle tick, no load
    @(negedge clk);
    {cur_h, cur_m, cur_s} = {5'd1, 6'd2, 6'd3};
    go(mk(0, 1, 0, 0, 0, 1, 0, 0, 1, 2, 3, 1));
    go(mk(0, 0, 1, 0, 0, 1, 0, 0, 2, 2, 3, 1));
    tick_run(1, 9, 1, 2, 2, 3);
    go(mk(0, 0, 0, 0, 1, 0, 1, 0, 2, 2, 3, 0));
    go(mk(0, 0, 0, 0, 0, 0, 1, 0, 2, 2, 3, 0));

    // inc on tick 9 restarts the count: survive tick 10, abort at tick 19
    go(mk(0, 1, 0, 0, 0, 1, 0, 0, 1, 2, 3, 1));
    go(mk(0, 0, 1, 0, 0, 1, 0, 0, 2, 2, 3, 1));
    tick_run(1, 8, 1, 2, 2, 3);
    go(mk(0, 0, 1, 0, 1, 1, 0, 0, 3, 2, 3, 0));
    tick_run(10, 18, 1, 3, 2, 3);
    go(mk(0, 0, 0, 0, 1, 0, 1, 0, 3, 2, 3, 0));
    go(mk(0, 0, 0, 0, 0, 0, 1, 0, 3, 2, 3, 0));

    // button on the expiring tick wins, then reset mid EDIT_MIN, then tick in RUN
    go(mk(0, 1, 0, 0, 0, 1, 0, 0, 1, 2, 3, 1));
    tick_run(1, 9, 1, 1, 2, 3);
    go(mk(0, 0, 0, 1, 1, 1, 0, 0, 0, 2, 3, 1));
    go(mk(0, 1, 0, 0, 0, 2, 0, 0, 0, 2, 3, 1));
    go(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    go(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    go(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
Button-driven time-setting sequencer for the hours/minutes/seconds timekeeper.
- Freezes the timekeeper and captures current time into shadow registers.
- Steps the user through hour, minute and second edit fields.
- Commits the edited value with a one-cycle load pulse, or abandons the edit after an inactivity timeout.
- Sits between the debounced front-panel buttons and the timekeeper's load/enable inputs.

Parameters:
HOUR_MAX, 23, highest hour value; hours wrap HOUR_MAX<->0.
MIN_MAX, 59, highest minute and second value; wrap MIN_MAX<->0.
TIMEOUT_SEC, 10, sec_tick count of inactivity in edit states before abort; 0 disables timeout.
TO_W, 8, width of the timeout counter; must hold TIMEOUT_SEC.

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
mode_btn  in  1  single-cycle pulse (debounced); advances edit field.
inc_btn  in  1  single-cycle pulse; increments current field.
dec_btn  in  1  single-cycle pulse; decrements current field.
sec_tick  in  1  single-cycle pulse once per second from timebase.
cur_hours  in  5  live hours from timekeeper.
cur_minutes  in  6  live minutes from timekeeper.
cur_seconds  in  6  live seconds from timekeeper.
run_en  out  1  1 = timekeeper counts; 0 = hold.
load  out  1  one-cycle pulse; timekeeper copies set_* on this cycle.
set_hours  out  5  shadow hours.
set_minutes  out  6  shadow minutes.
set_seconds  out  6  shadow seconds.
field  out  2  0 = RUN, 1 = hours, 2 = minutes, 3 = seconds (equals state encoding).
blink  out  1  display blink phase for the edited field.

Behaviour:
- Reset values: state RUN, run_en=1, load=0, set_* = 0, field=0, blink=0, timeout counter=0.
- All outputs are registered. A button sampled in cycle N is reflected in outputs at cycle N+1.
- States: RUN(0), EDIT_HR(1), EDIT_MIN(2), EDIT_SEC(3).
- RUN:
  - run_en=1.
  - On mode_btn: go to EDIT_HR and capture cur_* into set_* from the same sampling edge. run_en=0 from the next cycle.
  - inc_btn and dec_btn are ignored.
- EDIT_HR / EDIT_MIN / EDIT_SEC: inc/dec modify only the field for the current state.
  - inc: if value >= MAX then 0, else +1.
  - dec: if value == 0 or value > MAX then MAX, else -1.
  - MAX is HOUR_MAX for hours and MIN_MAX for minutes/seconds.
- Transitions on mode_btn: EDIT_HR -> EDIT_MIN -> EDIT_SEC -> RUN.
- Commit (mode_btn in EDIT_SEC): in the next cycle state=RUN, run_en=1, load=1 for exactly one cycle, and set_* hold the committed values. load returns to 0 the cycle after.
- Priority in one cycle: mode_btn over inc/dec (inc/dec dropped). inc_btn and dec_btn together: both ignored, no change.
- Timeout:
  - The counter clears on entry to any edit state and on any button pulse.
  - It increments on each sec_tick while in an edit state.
  - When it reaches TIMEOUT_SEC: go to RUN next cycle with run_en=1, load=0 (edit discarded), counter cleared.
  - A button in the same cycle as the expiring sec_tick wins; the counter clears and there is no abort.
  - TIMEOUT_SEC=0 never aborts.
- blink: 0 in RUN. Set to 1 on edit-state entry. Toggles on each sec_tick in edit states. Forced to 0 on return to RUN.
- set_* are unchanged in RUN except on capture. They hold their last value after commit or abort.
- Reset mid-edit: returns to reset values next cycle; no load pulse.
- Out-of-range cur_* values are captured as-is and corrected only by inc/dec wrap rules.

Test Plan:
- Reset, then idle 5 cycles -> run_en=1, load=0, field=0, set_*=0, blink=0.
- cur=12:34:56, pulse mode -> next cycle field=1, run_en=0, set=12:34:56. Then inc x3, mode, dec x35, mode, inc x4, mode -> one-cycle load with set=15:59:00, field=0, run_en=1.
- Wrap: in EDIT_HR with set_hours=23, inc -> 0; dec -> 23. In EDIT_MIN with 0, dec -> 59. Captured cur_minutes=62, inc -> 0.
- Timeout (TIMEOUT_SEC=10): enter edit, inc once, then 10 sec_ticks with no buttons -> RUN after the 10th, load never asserted. Repeat with an inc at tick 9 -> no abort at tick 10; abort at tick 19.
- Simultaneous: mode+inc in EDIT_HR -> field=2, hours unchanged. inc+dec together -> no change. Button coincident with the expiring tick -> stays in edit.
- Reset asserted in EDIT_MIN -> next cycle field=0, run_en=1, set_*=0, load=0; blink toggles only on sec_tick in edit states.
